// File: rtl/alu8_pkg.sv
// ---------------------------------------------------------------------------
// alu8_pkg
// Shared definitions for the 8-bit ALU slice: the 5-bit opcode enumeration,
// the bit positions of the status flags inside the packed flag vector, and a
// small helper that reports whether an opcode selects a supported operation.
//
// Configuration macro: ALU_MUL_EN (when defined, opcode 0x11 is a multiply).
// ---------------------------------------------------------------------------
package alu8_pkg;

    // Every operation the ALU understands. Codes 0x12..0x1F are left
    // unassigned and produce a zero result with only the zero flag set.
    typedef enum logic [4:0] {
        OP_ADD   = 5'h00,
        OP_ADC   = 5'h01,
        OP_SUB   = 5'h02,
        OP_SBB   = 5'h03,
        OP_INC   = 5'h04,
        OP_DEC   = 5'h05,
        OP_AND   = 5'h06,
        OP_OR    = 5'h07,
        OP_XOR   = 5'h08,
        OP_NOT   = 5'h09,
        OP_SHL   = 5'h0A,
        OP_SHR   = 5'h0B,
        OP_ASR   = 5'h0C,
        OP_ROL   = 5'h0D,
        OP_ROR   = 5'h0E,
        OP_CMP   = 5'h0F,
        OP_PASSB = 5'h10,
        OP_MUL   = 5'h11
    } opcode_e;

    // Positions of the status flags inside flags_t.
    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_BORROW   = 1;
    localparam int FLAG_ZERO     = 2;
    localparam int FLAG_NEGATIVE = 3;
    localparam int FLAG_OVERFLOW = 4;
    localparam int NUM_FLAGS     = 5;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    // True when the opcode maps to a real operation in this build. The
    // multiply code only counts when the multiplier is compiled in.
    function automatic logic is_valid_opcode(input logic [4:0] op);
`ifdef ALU_MUL_EN
        return (op <= 5'h11);
`else
        return (op <= 5'h10);
`endif
    endfunction

endpackage

// File: rtl/alu8_if.sv
// ---------------------------------------------------------------------------
// alu8_if
// Bundles the operand/opcode strobe and the registered result/status outputs
// of the ALU so the block and its driver can be connected with one port.
//
// master : drives opcode, operand_A, operand_B, enable, input_ready,
//          carry_in, borrow_in; observes result_out, result_ready and flags.
// slave  : the ALU side, the reverse directions.
// ---------------------------------------------------------------------------
interface alu8_if;
    import alu8_pkg::*;

    logic [4:0] opcode;
    logic [7:0] operand_A;
    logic [7:0] operand_B;
    logic       enable;
    logic       input_ready;
    logic       carry_in;
    logic       borrow_in;

    logic [7:0] result_out;
    logic       result_ready;
    logic       carry_out;
    logic       borrow_out;
    logic       zero;
    logic       negative;
    logic       overflow;

    modport master (
        output opcode, operand_A, operand_B, enable, input_ready,
               carry_in, borrow_in,
        input  result_out, result_ready, carry_out, borrow_out,
               zero, negative, overflow
    );

    modport slave (
        input  opcode, operand_A, operand_B, enable, input_ready,
               carry_in, borrow_in,
        output result_out, result_ready, carry_out, borrow_out,
               zero, negative, overflow
    );

endinterface

// File: rtl/alu8_addsub.sv
// ---------------------------------------------------------------------------
// alu8_addsub
// Shared 8-bit adder/subtractor used by every arithmetic opcode.
//
// a_i, b_i   : operands
// sub_i      : 0 -> a + b + cb_i, 1 -> a - b - cb_i
// cb_i       : carry-in (add) or borrow-in (subtract)
// sum_o      : 8-bit result, modulo 256
// carry_o    : carry out of bit 7 (add only)
// borrow_o   : unsigned minuend smaller than subtrahend plus borrow (sub only)
// overflow_o : signed two's-complement overflow
// ---------------------------------------------------------------------------
module alu8_addsub (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       sub_i,
    input  logic       cb_i,
    output logic [7:0] sum_o,
    output logic       carry_o,
    output logic       borrow_o,
    output logic       overflow_o
);

    logic [8:0] wide;

    // Work in 9 bits so that bit 8 is the carry for an add and, because a
    // negative difference wraps, also the borrow for a subtract.
    always_comb begin
        if (sub_i) begin
            wide = {1'b0, a_i} - {1'b0, b_i} - {8'b0, cb_i};
        end else begin
            wide = {1'b0, a_i} + {1'b0, b_i} + {8'b0, cb_i};
        end
    end

    assign sum_o    = wide[7:0];
    assign carry_o  = ~sub_i & wide[8];
    assign borrow_o =  sub_i & wide[8];

    // Signed overflow: for an add the operands share a sign that the result
    // lost; for a subtract the operands differ in sign and the result took
    // the sign of the subtrahend.
    assign overflow_o = sub_i ? ((a_i[7] ^ b_i[7]) & (a_i[7] ^ wide[7]))
                              : (~(a_i[7] ^ b_i[7]) & (a_i[7] ^ wide[7]));

endmodule

// File: rtl/alu8.sv
// ---------------------------------------------------------------------------
// alu8
// Registered 8-bit ALU. An operation starts on a rising clk edge where
// enable and input_ready are both high; the result and status flags are
// registered at that edge and result_ready is high for the following cycle.
//
// clk : single clock, rising edge
// rst : synchronous, active-low reset
// bus : alu8_if.slave (opcode, operands, strobes, result and flags)
//
// Configuration macro: ALU_MUL_EN -- when defined, opcode 0x11 returns the
// low byte of the unsigned product with carry_out = |high byte; otherwise
// 0x11 behaves like any unassigned opcode.
// ---------------------------------------------------------------------------
module alu8
    import alu8_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu8_if.slave bus
);

    opcode_e    op;
    logic       start;

    logic [7:0] asB;
    logic       asSub;
    logic       asCb;
    logic [7:0] asSum;
    logic       asCarry;
    logic       asBorrow;
    logic       asOverflow;

    logic [7:0] result_d;
    flags_t     flags_d;

    logic [7:0] result_q;
    flags_t     flags_q;
    logic       ready_q;

`ifdef ALU_MUL_EN
    logic [15:0] product;
    assign product = {8'b0, bus.operand_A} * {8'b0, bus.operand_B};
`endif

    assign op    = opcode_e'(bus.opcode);
    assign start = bus.enable & bus.input_ready;

    // Steer the shared adder: INC/DEC reuse it with a constant 1 as the
    // second operand, CMP is a plain subtract whose difference is discarded.
    always_comb begin
        asB   = bus.operand_B;
        asSub = 1'b0;
        asCb  = 1'b0;
        case (op)
            OP_ADC: asCb = bus.carry_in;
            OP_SUB,
            OP_CMP: asSub = 1'b1;
            OP_SBB: begin
                asSub = 1'b1;
                asCb  = bus.borrow_in;
            end
            OP_INC: asB = 8'h01;
            OP_DEC: begin
                asB   = 8'h01;
                asSub = 1'b1;
            end
            default: ;
        endcase
    end

    alu8_addsub u_addsub (
        .a_i        (bus.operand_A),
        .b_i        (asB),
        .sub_i      (asSub),
        .cb_i       (asCb),
        .sum_o      (asSum),
        .carry_o    (asCarry),
        .borrow_o   (asBorrow),
        .overflow_o (asOverflow)
    );

    // Result and flag selection. Zero and negative are derived from the
    // chosen result afterwards so every opcode, including the unassigned
    // ones, gets them consistently.
    always_comb begin
        result_d = 8'h00;
        flags_d  = '0;
        case (op)
            OP_ADD, OP_ADC, OP_INC: begin
                result_d                = asSum;
                flags_d[FLAG_CARRY]     = asCarry;
                flags_d[FLAG_OVERFLOW]  = asOverflow;
            end
            OP_SUB, OP_SBB, OP_DEC: begin
                result_d                = asSum;
                flags_d[FLAG_BORROW]    = asBorrow;
                flags_d[FLAG_OVERFLOW]  = asOverflow;
            end
            OP_CMP: begin
                result_d                = bus.operand_A;
                flags_d[FLAG_BORROW]    = asBorrow;
                flags_d[FLAG_OVERFLOW]  = asOverflow;
            end
            OP_AND: result_d = bus.operand_A & bus.operand_B;
            OP_OR:  result_d = bus.operand_A | bus.operand_B;
            OP_XOR: result_d = bus.operand_A ^ bus.operand_B;
            OP_NOT: result_d = ~bus.operand_A;
            OP_SHL: begin
                result_d            = {bus.operand_A[6:0], 1'b0};
                flags_d[FLAG_CARRY] = bus.operand_A[7];
            end
            OP_SHR: begin
                result_d            = {1'b0, bus.operand_A[7:1]};
                flags_d[FLAG_CARRY] = bus.operand_A[0];
            end
            OP_ASR: begin
                result_d            = {bus.operand_A[7], bus.operand_A[7:1]};
                flags_d[FLAG_CARRY] = bus.operand_A[0];
            end
            OP_ROL: begin
                result_d            = {bus.operand_A[6:0], bus.operand_A[7]};
                flags_d[FLAG_CARRY] = bus.operand_A[7];
            end
            OP_ROR: begin
                result_d            = {bus.operand_A[0], bus.operand_A[7:1]};
                flags_d[FLAG_CARRY] = bus.operand_A[0];
            end
            OP_PASSB: result_d = bus.operand_B;
`ifdef ALU_MUL_EN
            OP_MUL: begin
                result_d            = product[7:0];
                flags_d[FLAG_CARRY] = |product[15:8];
            end
`endif
            default: result_d = 8'h00;
        endcase
        flags_d[FLAG_ZERO]     = (result_d == 8'h00);
        flags_d[FLAG_NEGATIVE] = result_d[7];
    end

    // Output registers. Results and flags only move on a strobe so they hold
    // between operations; ready_q records that a strobe was taken and so is
    // high for exactly the cycle after it. Reset wins over a strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q <= 8'h00;
            flags_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= start;
            if (start) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    // The valid pulse is masked by rst so an operation strobed just before a
    // reset never announces a result in the cycle the reset is applied.
    assign bus.result_ready = ready_q & rst;
    assign bus.result_out   = result_q;
    assign bus.carry_out    = flags_q[FLAG_CARRY];
    assign bus.borrow_out   = flags_q[FLAG_BORROW];
    assign bus.zero         = flags_q[FLAG_ZERO];
    assign bus.negative     = flags_q[FLAG_NEGATIVE];
    assign bus.overflow     = flags_q[FLAG_OVERFLOW];

endmodule

// File: tb/tb_alu8.sv
// ---------------------------------------------------------------------------
// tb_alu8
// Self-checking bench for alu8. Expected results come from an integer
// reference model or from hand-written constants, are pushed onto a queue
// when an operation is strobed and popped when result_ready is seen.
//
// Configuration macro: ALU_MUL_EN (the model follows the same setting).
// ---------------------------------------------------------------------------
module tb_alu8;
    import alu8_pkg::*;

    typedef struct packed {
        logic [7:0] res;
        logic       carry;
        logic       borrow;
        logic       zero;
        logic       neg;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       bin;
        exp_t       exp;
        string      name;
    } vec_t;

    logic clk;
    logic rst;
    int   passCount;
    int   checkCount;
    exp_t qExp[$];

    alu8_if busIf ();

    alu8 dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf.slave)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot of the DUT result and flags in the same layout as exp_t.
    function automatic exp_t observed();
        return {busIf.result_out, busIf.carry_out, busIf.borrow_out,
                busIf.zero, busIf.negative, busIf.overflow};
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("res=%02h c=%b b=%b z=%b n=%b v=%b",
                         e.res, e.carry, e.borrow, e.zero, e.neg, e.ovf);
    endfunction

    // Reference model written with plain integers: unsigned values for the
    // carry/borrow, signed re-interpretations for overflow.
    function automatic exp_t model(input logic [4:0] op, input logic [7:0] a8,
                                   input logic [7:0] b8, input logic cin,
                                   input logic bin);
        int   a, b, s, sa, sb, sr;
        exp_t e;
        e  = '0;
        a  = int'(a8);
        b  = int'(b8);
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        s  = 0;
        sr = 0;
        case (op)
            5'h00: begin s = a + b;       sr = sa + sb;       e.carry  = (s > 255); end
            5'h01: begin s = a + b + cin; sr = sa + sb + cin; e.carry  = (s > 255); end
            5'h02: begin s = a - b;       sr = sa - sb;       e.borrow = (s < 0);   end
            5'h03: begin s = a - b - bin; sr = sa - sb - bin; e.borrow = (s < 0);   end
            5'h04: begin s = a + 1;       sr = sa + 1;        e.carry  = (s > 255); end
            5'h05: begin s = a - 1;       sr = sa - 1;        e.borrow = (s < 0);   end
            5'h06: s = a & b;
            5'h07: s = a | b;
            5'h08: s = a ^ b;
            5'h09: s = 255 - a;
            5'h0A: begin s = a * 2;                 e.carry = (a >= 128); end
            5'h0B: begin s = a / 2;                 e.carry = a[0];       end
            5'h0C: begin s = a / 2 + (a & 128);     e.carry = a[0];       end
            5'h0D: begin s = a * 2 + a / 128;       e.carry = (a >= 128); end
            5'h0E: begin s = a / 2 + (a % 2) * 128; e.carry = a[0];       end
            5'h0F: begin
                s        = a;
                sr       = sa - sb;
                e.borrow = (a < b);
            end
            5'h10: s = b;
`ifdef ALU_MUL_EN
            5'h11: begin s = a * b; e.carry = (s > 255); end
`endif
            default: s = 0;
        endcase
        e.res = s[7:0];
        if (op <= 5'h05 || op == 5'h0F) e.ovf = (sr > 127) || (sr < -128);
        e.zero = (e.res == 8'h00);
        e.neg  = (e.res >= 8'h80);
        return e;
    endfunction

    // Stimulus only: present one operation with both strobes high.
    task automatic applyStimulus(input logic [4:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin,
                                 input logic bin);
        busIf.opcode      = op;
        busIf.operand_A   = a;
        busIf.operand_B   = b;
        busIf.carry_in    = cin;
        busIf.borrow_in   = bin;
        busIf.enable      = 1'b1;
        busIf.input_ready = 1'b1;
    endtask

    task automatic goIdle();
        busIf.enable      = 1'b0;
        busIf.input_ready = 1'b0;
    endtask

    // Reset clears everything and beats a strobe presented in the same cycle.
    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(5'h00, 8'h7F, 8'h01, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (observed() !== exp_t'(0) || busIf.result_ready !== 1'b0)
            $display("[TB] FAIL reset_state: got %s rdy=%b, expected all zero",
                     fmt(observed()), busIf.result_ready);
        else passCount++;
        @(negedge clk);
        rst = 1'b1;
        goIdle();
        @(posedge clk);
        #1;
        checkCount++;
        if (busIf.result_ready !== 1'b0 || busIf.result_out !== 8'h00)
            $display("[TB] FAIL reset_beats_strobe: got res=%02h rdy=%b, expected res=00 rdy=0",
                     busIf.result_out, busIf.result_ready);
        else passCount++;
    endtask

    // Directed corner cases with hand-derived expectations, each followed by
    // an idle cycle to confirm the valid pulse lasts exactly one cycle.
    task automatic test_vectors();
        vec_t vecs[$];
        exp_t got, want;
        vecs.push_back('{5'h00, 8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, "add_ff_01"});
        vecs.push_back('{5'h00, 8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}, "add_7f_01"});
        vecs.push_back('{5'h03, 8'h05, 8'h05, 1'b0, 1'b1, '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, "sbb_05_05"});
        vecs.push_back('{5'h0F, 8'h10, 8'h20, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, "cmp_10_20"});
        vecs.push_back('{5'h0E, 8'h01, 8'h00, 1'b0, 1'b0, '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, "ror_01"});
        vecs.push_back('{5'h0C, 8'h80, 8'h00, 1'b0, 1'b0, '{8'hC0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, "asr_80"});
`ifdef ALU_MUL_EN
        vecs.push_back('{5'h11, 8'h10, 8'h20, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, "mul_10_20"});
`else
        vecs.push_back('{5'h11, 8'h10, 8'h20, 1'b0, 1'b0, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, "mul_10_20"});
`endif
        vecs.push_back('{5'h01, 8'h7F, 8'h00, 1'b1, 1'b0, '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}, "adc_7f_00_c"});
        vecs.push_back('{5'h10, 8'h12, 8'hA5, 1'b0, 1'b0, '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, "passb_a5"});
        vecs.push_back('{5'h15, 8'h55, 8'h66, 1'b1, 1'b1, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, "invalid_15"});
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].bin);
            qExp.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            checkCount++;
            if (busIf.result_ready !== 1'b1 || qExp.size() == 0) begin
                $display("[TB] FAIL %s_ready: got rdy=%b, expected rdy=1", vecs[i].name,
                         busIf.result_ready);
                qExp.delete();
            end else begin
                passCount++;
                want = qExp.pop_front();
                got  = observed();
                checkCount++;
                if (got !== want)
                    $display("[TB] FAIL %s: got %s, expected %s", vecs[i].name, fmt(got), fmt(want));
                else passCount++;
            end
            @(negedge clk);
            goIdle();
            @(posedge clk);
            #1;
            checkCount++;
            if (busIf.result_ready !== 1'b0)
                $display("[TB] FAIL %s_pulse_width: got rdy=%b, expected rdy=0", vecs[i].name,
                         busIf.result_ready);
            else passCount++;
        end
    endtask

    // Random operations strobed every cycle: one result per cycle, checked
    // against the integer model.
    task automatic test_back_to_back();
        logic [4:0] op;
        logic [7:0] a, b;
        logic       cin, bin;
        exp_t       got, want;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            op  = 5'($urandom_range(0, 31));
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            cin = 1'($urandom_range(0, 1));
            bin = 1'($urandom_range(0, 1));
            applyStimulus(op, a, b, cin, bin);
            qExp.push_back(model(op, a, b, cin, bin));
            @(posedge clk);
            #1;
            if (busIf.result_ready === 1'b1 && qExp.size() != 0) begin
                want = qExp.pop_front();
                got  = observed();
                checkCount++;
                if (got !== want)
                    $display("[TB] FAIL b2b_op%02h a=%02h b=%02h: got %s, expected %s",
                             op, a, b, fmt(got), fmt(want));
                else passCount++;
            end else begin
                checkCount++;
                $display("[TB] FAIL b2b_ready iter %0d: got rdy=%b, expected rdy=1",
                         i, busIf.result_ready);
            end
        end
        @(negedge clk);
        goIdle();
        @(posedge clk);
        #1;
        checkCount++;
        if (busIf.result_ready !== 1'b0 || qExp.size() != 0)
            $display("[TB] FAIL b2b_drain: got rdy=%b pending=%0d, expected rdy=0 pending=0",
                     busIf.result_ready, qExp.size());
        else passCount++;
    endtask

    // With either strobe low nothing is taken: outputs hold and no pulse.
    task automatic test_hold();
        exp_t held;
        held = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        applyStimulus(5'h00, 8'h7F, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(5'h08, 8'h0F, 8'h0F, 1'b0, 1'b0);
        busIf.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkCount++;
            if (busIf.result_ready !== 1'b0 || observed() !== held)
                $display("[TB] FAIL hold_%0d: got %s rdy=%b, expected %s rdy=0",
                         i, fmt(observed()), busIf.result_ready, fmt(held));
            else passCount++;
            @(negedge clk);
            busIf.enable      = (i % 2 == 0);
            busIf.input_ready = (i % 2 != 0);
        end
        goIdle();
    endtask

    // A reset applied in the cycle a result would be announced hides the
    // pulse and then clears the outputs at the next edge.
    task automatic test_reset_in_pulse();
        @(negedge clk);
        applyStimulus(5'h09, 8'h0F, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        goIdle();
        rst = 1'b0;
        #1;
        checkCount++;
        if (busIf.result_ready !== 1'b0)
            $display("[TB] FAIL reset_pulse_suppressed: got rdy=%b, expected rdy=0",
                     busIf.result_ready);
        else passCount++;
        @(posedge clk);
        #1;
        checkCount++;
        if (observed() !== exp_t'(0) || busIf.result_ready !== 1'b0)
            $display("[TB] FAIL reset_in_pulse_clear: got %s rdy=%b, expected all zero",
                     fmt(observed()), busIf.result_ready);
        else passCount++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst        = 1'b0;
        goIdle();
        busIf.opcode    = 5'h00;
        busIf.operand_A = 8'h00;
        busIf.operand_B = 8'h00;
        busIf.carry_in  = 1'b0;
        busIf.borrow_in = 1'b0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_hold();
        test_reset_in_pulse();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu8.md
ALU8 -- requirements
Module: alu8

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-low.
REQ-003 opcode  in  5  operation select (table REQ-012).
REQ-004 operand_A  in  8  first operand; operand_B  in  8  second operand.
REQ-005 enable  in  1  block enable; input_ready  in  1  operands/opcode valid strobe.
REQ-006 carry_in  in  1  carry for ADC; borrow_in  in  1  borrow for SBB.
REQ-007 result_out  out  8  registered result; result_ready  out  1  one-cycle result-valid pulse.
REQ-008 carry_out, borrow_out, zero, negative, overflow  out  1 each  registered status flags.

Function
REQ-009 Operation SHALL start on a rising clk edge with rst=1, enable=1, input_ready=1; opcode, operands, carry_in and borrow_in are sampled at that edge.
REQ-010 result_out and all flags SHALL update at that same edge (latency 1); result_ready SHALL be 1 for exactly the following cycle.
REQ-011 With enable=0 or input_ready=0, result_out and flags SHALL hold; result_ready SHALL be 0; back-to-back strobes SHALL yield one result per cycle.
REQ-012 Opcodes: 00 ADD A+B; 01 ADC A+B+cin; 02 SUB A-B; 03 SBB A-B-bin; 04 INC A+1; 05 DEC A-1; 06 AND; 07 OR; 08 XOR; 09 NOT A; 0A SHL; 0B SHR logical; 0C ASR; 0D ROL; 0E ROR; 0F CMP; 10 PASSB; 11 MUL.
REQ-013 All arithmetic SHALL be 8-bit modulo 256 with 9-bit internal sum.
REQ-014 carry_out SHALL be bit 8 of the sum for ADD/ADC/INC, bit shifted out for SHL/ROL (A[7]) and SHR/ASR/ROR (A[0]), |high byte for MUL, else 0.
REQ-015 borrow_out SHALL be 1 for SUB/SBB/DEC/CMP when unsigned minuend < subtrahend (incl. borrow term), else 0.
REQ-016 overflow SHALL be signed two's-complement overflow for ADD/ADC/INC/SUB/SBB/DEC/CMP, else 0.
REQ-017 zero SHALL be (result==0) and negative SHALL be result[7] for every opcode.
REQ-018 CMP SHALL set flags from A-B while result_out = operand_A; PASSB SHALL give result_out = operand_B.
REQ-019 Opcodes 12-1F (and 11 when MUL excluded) SHALL give result_out=0x00, zero=1, other flags 0, result_ready still pulsed.

Reset
REQ-020 On rising clk with rst=0: result_out=0x00, all flags=0, result_ready=0; reset SHALL override a simultaneous strobe.
REQ-021 An operation strobed the cycle before reset SHALL have its result_ready pulse suppressed if rst=0 in the pulse cycle.

Configuration
REQ-022 Macro ALU_MUL_EN: defined -> opcode 11 returns low byte of A*B (unsigned), carry_out = |high byte; undefined -> no multiplier, opcode 11 handled per REQ-019.

Structure
REQ-023 Package alu8_pkg SHALL hold the opcode enumeration (5-bit) and flag-index constants.
REQ-024 One sub-module alu8_addsub (8-bit add/subtract with carry/borrow in, carry, borrow, overflow out) SHALL be instantiated; the rest is combinational mux plus output registers.

Verification
REQ-025 ADD A=0xFF B=0x01 -> result 0x00, carry=1, zero=1, overflow=0, result_ready pulse 1 cycle later.
REQ-026 ADD A=0x7F B=0x01 -> 0x80, overflow=1, negative=1, carry=0.
REQ-027 SBB A=0x05 B=0x05 bin=1 -> 0xFF, borrow=1, negative=1; CMP A=0x10 B=0x20 -> result 0x10, borrow=1.
REQ-028 ROR A=0x01 -> 0x80, carry=1; ASR A=0x80 -> 0xC0, carry=0.
REQ-029 MUL A=0x10 B=0x20 -> 0x00, carry=1 with ALU_MUL_EN; 0x00, zero=1, carry=0 without.
REQ-030 Strobe with enable=0 -> outputs hold, no result_ready; rst=0 during result cycle -> all outputs 0.
